// File: rtl/adder_32b.sv
// Registered 32-bit carry-lookahead adder (8 x 4-bit groups) with carry-out and signed overflow.
// Build option ADDER_PIPE2_EN splits the add into two 16-bit pipeline stages (latency 2).

module adder_32b_cla #(
  parameter int GROUPS = 8
) (
  input  logic [4*GROUPS-1:0] a,
  input  logic [4*GROUPS-1:0] b,
  input  logic                cin,
  output logic [4*GROUPS-1:0] s,
  output logic                c_top,
  output logic                cout
);
  localparam int W = 4 * GROUPS;

  logic [W-1:0]      p;
  logic [W-1:0]      g;
  logic [GROUPS-1:0] gg;
  logic [GROUPS-1:0] gp;
  logic [GROUPS:0]   gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin : group_pg
    gg = '0;
    gp = '0;
    for (int k = 0; k < GROUPS; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | ((&p[4*k+2 +: 2]) & g[4*k+1])
            | ((&p[4*k+1 +: 3]) & g[4*k]);
    end
  end

  // Second level: every group carry is a flat sum of products of group g/p and cin.
  always_comb begin : lookahead
    logic prod;
    logic allp;
    gc    = '0;
    gc[0] = cin;
    prod  = 1'b0;
    allp  = 1'b0;
    for (int k = 0; k < GROUPS; k++) begin
      allp = cin;
      for (int i = 0; i <= k; i++) allp = allp & gp[i];
      gc[k+1] = allp;
      for (int j = 0; j <= k; j++) begin
        prod = gg[j];
        for (int i = j + 1; i <= k; i++) prod = prod & gp[i];
        gc[k+1] = gc[k+1] | prod;
      end
    end
  end

  always_comb begin : bit_sums
    logic cc;
    s     = '0;
    c_top = 1'b0;
    cc    = 1'b0;
    for (int k = 0; k < GROUPS; k++) begin
      cc = gc[k];
      for (int bi = 0; bi < 4; bi++) begin
        s[4*k+bi] = p[4*k+bi] ^ cc;
        if (4*k + bi == W - 1) c_top = cc;
        cc = g[4*k+bi] | (p[4*k+bi] & cc);
      end
    end
  end

  assign cout = gc[GROUPS];
endmodule

module adder_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic        out_valid,
  output logic [31:0] sum,
  output logic        c_out,
  output logic        ovf
);
`ifdef ADDER_PIPE2_EN
  logic [15:0] lo_sum;
  logic        lo_c16;
  logic        lo_c15_unused;
  logic        s1_valid;
  logic [15:0] s1_sum_lo;
  logic        s1_c16;
  logic [15:0] s1_x_hi;
  logic [15:0] s1_y_hi;
  logic [15:0] hi_sum;
  logic        hi_c31;
  logic        hi_c32;

  adder_32b_cla #(.GROUPS(4)) u_cla_lo (
    .a(x[15:0]), .b(y[15:0]), .cin(c_in),
    .s(lo_sum), .c_top(lo_c15_unused), .cout(lo_c16)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum_lo <= '0;
      s1_c16    <= 1'b0;
      s1_x_hi   <= '0;
      s1_y_hi   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum_lo <= lo_sum;
        s1_c16    <= lo_c16;
        s1_x_hi   <= x[31:16];
        s1_y_hi   <= y[31:16];
      end
    end
  end

  adder_32b_cla #(.GROUPS(4)) u_cla_hi (
    .a(s1_x_hi), .b(s1_y_hi), .cin(s1_c16),
    .s(hi_sum), .c_top(hi_c31), .cout(hi_c32)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= {hi_sum, s1_sum_lo};
        c_out <= hi_c32;
        ovf   <= hi_c31 ^ hi_c32;
      end
    end
  end
`else
  logic [31:0] sum_c;
  logic        c31;
  logic        c32;

  adder_32b_cla #(.GROUPS(8)) u_cla (
    .a(x), .b(y), .cin(c_in),
    .s(sum_c), .c_top(c31), .cout(c32)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_c;
        c_out <= c32;
        ovf   <= c31 ^ c32;
      end
    end
  end
`endif
endmodule

// File: tb/tb_adder_32b.sv
// Self-checking bench for adder_32b: arithmetic reference model with latency delay line,
// directed literal cases, streaming, mid-stream reset and randomized traffic.

module tb_adder_32b;
`ifdef ADDER_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        c_in;
  logic        out_valid;
  logic [31:0] sum;
  logic        c_out;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  adder_32b dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .c_in(c_in),
    .out_valid(out_valid), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // result packing: {ovf, c_out, sum}
  function automatic logic [33:0] ref_add(logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    v = (a[31] == b[31]) && (t[31] != a[31]);
    return {v, t[32], t[31:0]};
  endfunction

  task automatic check(string name, logic [33:0] got, logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a plain delay line of LAT operations plus held output values.
  logic        pv[LAT];
  logic [33:0] pr[LAT];
  logic        m_valid = 1'b0;
  logic [33:0] m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0;
        pr[i] = '0;
      end
      m_valid = 1'b0;
      m_res   = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pr[i] = pr[i-1];
      end
      pv[0] = in_valid;
      pr[0] = ref_add(x, y, c_in);
      m_valid = pv[LAT-1];
      if (pv[LAT-1]) m_res = pr[LAT-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", {33'd0, out_valid}, {33'd0, m_valid});
      check("model_result", {ovf, c_out, sum}, m_res);
    end
  end

  logic [31:0] cx[6]  = '{32'h00000000, 32'h00000001, 32'h80000000, 32'h00000F81, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic [31:0] cy[6]  = '{32'h00000001, 32'h00000001, 32'h80000001, 32'h000000F1, 32'h00000000, 32'h00000001};
  logic        cc[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [33:0] cexp[6] = '{{2'b00, 32'h00000001}, {2'b00, 32'h00000003}, {2'b11, 32'h00000001},
                           {2'b00, 32'h00001072}, {2'b01, 32'h00000000}, {2'b10, 32'h80000000}};

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(7))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the result must be visible.
  task automatic run_one(int i);
    x = cx[i]; y = cy[i]; c_in = cc[i]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check($sformatf("case%0d_valid", i), {33'd0, out_valid}, 34'd1);
    check($sformatf("case%0d_result", i), {ovf, c_out, sum}, cexp[i]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {out_valid, ovf, c_out, sum}, 34'd0);
    in_valid = 1'b1; x = 32'hFFFFFFFF; y = 32'h1;
    @(negedge clk);
    check("reset_ignores_in_valid", {out_valid, ovf, c_out, sum}, 34'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_one(i);
    @(negedge clk);

    // Four cases back-to-back; results must appear on consecutive cycles, in order.
    for (int k = 0; k < 4 + LAT + 1; k++) begin
      if (k >= LAT && k - LAT <= 3) begin
        check($sformatf("stream%0d_valid", k), {33'd0, out_valid}, 34'd1);
        check($sformatf("stream%0d_result", k), {ovf, c_out, sum}, cexp[k - LAT]);
      end else begin
        check($sformatf("stream%0d_idle", k), {33'd0, out_valid}, 34'd0);
      end
      if (k < 4) begin
        x = cx[k]; y = cy[k]; c_in = cc[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset in the middle of a stream discards everything in flight.
    for (int k = 0; k < 3; k++) begin
      x = $urandom; y = $urandom; c_in = 1'($urandom_range(1)); in_valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midstream_reset", {out_valid, ovf, c_out, sum}, 34'd0);
    rst = 1'b0;
    x = cx[2]; y = cy[2]; c_in = cc[2]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) begin
      check("post_reset_no_early_valid", {33'd0, out_valid}, 34'd0);
      @(negedge clk);
    end
    check("post_reset_valid", {33'd0, out_valid}, 34'd1);
    check("post_reset_result", {ovf, c_out, sum}, cexp[2]);

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(3) != 0);
      x        = rnd_operand();
      y        = rnd_operand();
      c_in     = 1'($urandom_range(1));
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
